// File: rtl/pe_soc_pkg.sv
// Shared SoC peripheral package.
// Holds the word-address map of the peripheral block, the register offsets
// of the switch controller, a register-select enum and the address decoder
// used by the switch controller.
package pe_soc_pkg;

  // Peripheral base word addresses (low nibble zero so offsets can be added).
  localparam logic [11:0] PE_UART_BASE   = 12'h040;
  localparam logic [11:0] PE_TIMER_BASE  = 12'h050;
  localparam logic [11:0] PE_SWITCH_BASE = 12'h070;

  // Switch controller register offsets.
  localparam logic [11:0] PE_SW_STATE_OFS   = 12'h000;
  localparam logic [11:0] PE_SW_CHANGED_OFS = 12'h004;
  localparam logic [11:0] PE_SW_IRQ_EN_OFS  = 12'h008;

  typedef enum logic [1:0] {
    SW_REG_NONE,
    SW_REG_STATE,
    SW_REG_CHANGED,
    SW_REG_IRQ_EN
  } pe_sw_reg_e;

  // Map a bus address onto a switch-controller register, or NONE.
  function automatic pe_sw_reg_e pe_sw_decode(input logic [11:0] addr,
                                              input logic [11:0] base);
    if (addr == base + PE_SW_STATE_OFS)   return SW_REG_STATE;
    if (addr == base + PE_SW_CHANGED_OFS) return SW_REG_CHANGED;
    if (addr == base + PE_SW_IRQ_EN_OFS)  return SW_REG_IRQ_EN;
    return SW_REG_NONE;
  endfunction

endpackage

// File: rtl/pe_switch_ctrl_if.sv
// Register bus of the switch controller.
//   addr  : word address (master -> slave)
//   we    : 1-cycle write strobe (master -> slave)
//   wdata : write data (master -> slave)
//   data  : registered read data (slave -> master)
//   irq   : registered level interrupt (slave -> master)
interface pe_switch_ctrl_if;
  logic [11:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] data;
  logic        irq;

  modport master (output addr, output we, output wdata,
                  input  data, input  irq);
  modport slave  (input  addr, input  we, input  wdata,
                  output data, output irq);
endinterface

// File: rtl/pe_dbnc_bit.sv
// Single-channel switch debouncer.
// Two-flop synchroniser, then a run-length counter that accepts the
// synchronised level once it has differed from the debounced level for
// DBNC_CYC consecutive edges.
//   clk, rst : clock, async active-high reset
//   sw       : raw asynchronous switch level
//   level    : debounced level
//   upd      : high in the cycle whose rising edge updates level
module pe_dbnc_bit #(
  parameter int DBNC_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic level,
  output logic upd
);

  localparam int                CNT_W    = $clog2(DBNC_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DBNC_CYC - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // Stage p0/p1: metastability synchroniser
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= sw;
      sync_p1 <= sync_p0;
    end
  end

  // The edge that would bring the count to DBNC_CYC is the accepting edge,
  // so the update is flagged combinationally one count early.
  assign upd = (sync_p1 != level) && (cnt == CNT_LAST);

  // Debounce stage: counter and accepted level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_p1 == level) begin
      cnt <= '0;
    end else if (upd) begin
      level <= sync_p1;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pe_switch_ctrl.sv
// Debounced switch bank with sticky change flags and interrupt.
// Registers (word addresses relative to BASE_ADDR):
//   +0 STATE   RO  debounced levels
//   +4 CHANGED W1C sticky per-channel change flags
//   +8 IRQ_EN  RW  interrupt mask
//   clk, rst : clock, async active-high reset
//   switches : raw asynchronous switch levels, high = on
//   bus      : register bus (addr/we/wdata in, data/irq out)
module pe_switch_ctrl
  import pe_soc_pkg::*;
#(
  parameter int          N_SW      = 24,
  parameter int          DBNC_CYC  = 16,
  parameter logic [11:0] BASE_ADDR = 12'h070
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] switches,
  pe_switch_ctrl_if.slave bus
);

  logic [N_SW-1:0] state;
  logic [N_SW-1:0] upd;
  logic [N_SW-1:0] changed;
  logic [N_SW-1:0] irq_en;
  logic [N_SW-1:0] clr_mask;
  logic [31:0]     rd_val;
  logic [31:0]     unused_wdata;
  logic            rd_vld;
  pe_sw_reg_e      sel;

  for (genvar gi = 0; gi < N_SW; gi++) begin : g_dbnc
    pe_dbnc_bit #(
      .DBNC_CYC (DBNC_CYC)
    ) u_dbnc (
      .clk   (clk),
      .rst   (rst),
      .sw    (switches[gi]),
      .level (state[gi]),
      .upd   (upd[gi])
    );
  end

  assign sel = pe_sw_decode(bus.addr, BASE_ADDR);

  // Write-data bits above N_SW have no register behind them.
  assign unused_wdata = bus.wdata;

  always_comb begin
    clr_mask = '0;
    if (bus.we && (sel == SW_REG_CHANGED)) clr_mask = bus.wdata[N_SW-1:0];
  end

  // Register stage: change flags (a same-edge update beats the clear) and mask
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      changed <= '0;
      irq_en  <= '0;
    end else begin
      changed <= (changed & ~clr_mask) | upd;
      if (bus.we && (sel == SW_REG_IRQ_EN)) irq_en <= bus.wdata[N_SW-1:0];
    end
  end

  always_comb begin
    rd_val = '0;
    rd_vld = !bus.we && (sel != SW_REG_NONE);
    case (sel)
      SW_REG_STATE:   rd_val[N_SW-1:0] = state;
      SW_REG_CHANGED: rd_val[N_SW-1:0] = changed;
      SW_REG_IRQ_EN:  rd_val[N_SW-1:0] = irq_en;
      default:        rd_val = '0;
    endcase
  end

  // Output stage: read data holds unless a mapped read occurs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.data <= '0;
      bus.irq  <= 1'b0;
    end else begin
      if (rd_vld) bus.data <= rd_val;
      bus.irq <= |(changed & irq_en);
    end
  end

endmodule

// File: tb/tb_pe_switch_ctrl.sv
// Directed self-checking bench for pe_switch_ctrl (N_SW=24, DBNC_CYC=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_pe_switch_ctrl;
  import pe_soc_pkg::*;

  localparam int          N_SW = 24;
  localparam int          DBNC = 4;
  localparam logic [11:0] BASE = 12'h070;
  localparam logic [11:0] A_ST = BASE + 12'h0;
  localparam logic [11:0] A_CH = BASE + 12'h4;
  localparam logic [11:0] A_IE = BASE + 12'h8;
  localparam logic [11:0] A_UN = 12'h0C0;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_SW-1:0] switches = '0;
  int              n_vec = 0;
  int              n_err = 0;

  pe_switch_ctrl_if bus ();

  pe_switch_ctrl #(
    .N_SW      (N_SW),
    .DBNC_CYC  (DBNC),
    .BASE_ADDR (BASE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .switches (switches),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.we    = 1'b1;
    bus.wdata = d;
    @(negedge clk);
    bus.we    = 1'b0;
    bus.addr  = 12'h000;
    bus.wdata = '0;
  endtask

  task automatic do_read(input logic [11:0] a, output logic [31:0] d);
    bus.addr = a;
    bus.we   = 1'b0;
    @(negedge clk);
    d = bus.data;
    bus.addr = 12'h000;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    n_vec++;
    if (bus.data !== 32'h0) begin
      n_err++; $display("FAIL reset_data: got %h want %h", bus.data, 32'h0);
    end
    n_vec++;
    if (bus.irq !== 1'b0) begin
      n_err++; $display("FAIL reset_irq: got %b want 0", bus.irq);
    end
    rst = 1'b0;
    do_read(A_ST, v);
    n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL reset_state: got %h want 0", v); end
    do_read(A_CH, v);
    n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL reset_changed: got %h want 0", v); end
    do_read(A_IE, v);
    n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL reset_irq_en: got %h want 0", v); end
  endtask

  task automatic test_debounce_latency;
    logic [31:0] v;
    logic [31:0] exp;
    switches = 24'h00000F;
    bus.addr = A_ST;
    bus.we   = 1'b0;
    // after edge k+m, data shows STATE from before that edge: F appears at m=6
    for (int m = 0; m <= 6; m++) begin
      @(negedge clk);
      exp = (m >= 6) ? 32'h0000000F : 32'h0;
      n_vec++;
      if (bus.data !== exp) begin
        n_err++; $display("FAIL latency_m%0d: got %h want %h", m, bus.data, exp);
      end
    end
    do_read(A_CH, v);
    n_vec++;
    if (v !== 32'h0000000F) begin n_err++; $display("FAIL latency_changed: got %h want 0000000f", v); end
    n_vec++;
    if (bus.irq !== 1'b0) begin n_err++; $display("FAIL latency_irq_masked: got %b want 0", bus.irq); end
    switches = '0;
    tick(8);
    do_write(A_CH, 32'h0000000F);
    do_read(A_CH, v);
    n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL latency_w1c: got %h want 0", v); end
  endtask

  task automatic test_glitch;
    logic [31:0] v;
    do_write(A_IE, 32'h00000001);
    switches[0] = 1'b1;
    tick(3);
    switches[0] = 1'b0;
    for (int m = 0; m < 8; m++) begin
      @(negedge clk);
      n_vec++;
      if (bus.irq !== 1'b0) begin n_err++; $display("FAIL glitch_irq_c%0d: got %b want 0", m, bus.irq); end
    end
    do_read(A_ST, v);
    n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL glitch_state: got %h want 0", v); end
    do_read(A_CH, v);
    n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL glitch_changed: got %h want 0", v); end
  endtask

  task automatic test_irq;
    logic [31:0] v;
    logic        exp;
    switches = 24'h000001;
    // CHANGED[0] sets at edge k+5, irq follows at k+6
    for (int m = 0; m <= 6; m++) begin
      @(negedge clk);
      exp = (m >= 6);
      n_vec++;
      if (bus.irq !== exp) begin n_err++; $display("FAIL irq_rise_m%0d: got %b want %b", m, bus.irq, exp); end
    end
    do_read(A_CH, v);
    n_vec++;
    if (v !== 32'h1) begin n_err++; $display("FAIL irq_changed: got %h want 00000001", v); end
    do_write(A_CH, 32'h00000001);
    n_vec++;
    if (bus.irq !== 1'b1) begin n_err++; $display("FAIL irq_hold_on_clear_edge: got %b want 1", bus.irq); end
    @(negedge clk);
    n_vec++;
    if (bus.irq !== 1'b0) begin n_err++; $display("FAIL irq_fall: got %b want 0", bus.irq); end
    do_read(A_CH, v);
    n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL irq_changed_cleared: got %h want 0", v); end
  endtask

  task automatic test_set_wins;
    logic [31:0] v;
    switches = '0;
    tick(5);
    // the write lands on edge k+5, the same edge bit0 updates back to 0
    do_write(A_CH, 32'h00000001);
    do_read(A_CH, v);
    n_vec++;
    if (v !== 32'h1) begin n_err++; $display("FAIL set_wins_changed: got %h want 00000001", v); end
    n_vec++;
    if (bus.irq !== 1'b1) begin n_err++; $display("FAIL set_wins_irq: got %b want 1", bus.irq); end
    do_read(A_ST, v);
    n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL set_wins_state: got %h want 0", v); end
    do_write(A_CH, 32'h00000001);
  endtask

  task automatic test_read_hold;
    logic [31:0] v;
    switches = 24'h000030;
    tick(8);
    do_read(A_ST, v);
    n_vec++;
    if (v !== 32'h30) begin n_err++; $display("FAIL hold_state_pre: got %h want 00000030", v); end
    do_write(A_CH, 32'h00000030);
    bus.addr = A_UN;
    switches = 24'h0C0000;
    for (int m = 0; m < 10; m++) begin
      @(negedge clk);
      n_vec++;
      if (bus.data !== 32'h30) begin n_err++; $display("FAIL hold_c%0d: got %h want 00000030", m, bus.data); end
    end
    do_write(A_ST, 32'hFFFFFFFF);
    n_vec++;
    if (bus.data !== 32'h30) begin n_err++; $display("FAIL hold_on_write: got %h want 00000030", bus.data); end
    do_read(A_ST, v);
    n_vec++;
    if (v !== 32'h000C0000) begin n_err++; $display("FAIL hold_state_post: got %h want 000c0000", v); end
    do_write(12'h07C, 32'hFFFFFFFF);
    do_read(A_IE, v);
    n_vec++;
    if (v !== 32'h1) begin n_err++; $display("FAIL unmapped_write: got %h want 00000001", v); end
    do_write(A_IE, 32'hFFFFFFFF);
    do_read(A_IE, v);
    n_vec++;
    if (v !== 32'h00FFFFFF) begin n_err++; $display("FAIL irq_en_width: got %h want 00ffffff", v); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    logic [31:0] exp;
    switches = 24'hFFFFFF;
    tick(3);
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.data !== 32'h0) begin n_err++; $display("FAIL rst_mid_data: got %h want 0", bus.data); end
    n_vec++;
    if (bus.irq !== 1'b0) begin n_err++; $display("FAIL rst_mid_irq: got %b want 0", bus.irq); end
    tick(2);
    rst      = 1'b0;
    bus.addr = A_ST;
    bus.we   = 1'b0;
    for (int m = 0; m <= 6; m++) begin
      @(negedge clk);
      exp = (m >= 6) ? 32'h00FFFFFF : 32'h0;
      n_vec++;
      if (bus.data !== exp) begin n_err++; $display("FAIL rst_release_m%0d: got %h want %h", m, bus.data, exp); end
    end
    do_read(A_CH, v);
    n_vec++;
    if (v !== 32'h00FFFFFF) begin n_err++; $display("FAIL rst_changed: got %h want 00ffffff", v); end
    do_read(A_IE, v);
    n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL rst_irq_en: got %h want 0", v); end
    n_vec++;
    if (bus.irq !== 1'b0) begin n_err++; $display("FAIL rst_irq_after: got %b want 0", bus.irq); end
  endtask

  initial begin
    bus.addr  = 12'h000;
    bus.we    = 1'b0;
    bus.wdata = '0;
    tick(2);
    test_reset();
    test_debounce_latency();
    test_glitch();
    test_irq();
    test_set_wins();
    test_read_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pe_switch_ctrl.md
PE_SWITCH_CTRL -- requirements
Module: pe_switch_ctrl

Interface
REQ-001 Parameter N_SW, default 24, number of switch channels; legal range 1..32.
REQ-002 Parameter DBNC_CYC, default 16, consecutive stable cycles needed to accept a new level; legal range 1..65535.
REQ-003 Parameter BASE_ADDR, default 12'h070, word address of register block; BASE_ADDR[3:0] SHALL be 0.
REQ-004 clk  input  1  clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 addr  input  12  bus address.
REQ-007 we  input  1  bus write strobe, 1-cycle pulse.
REQ-008 wdata  input  32  bus write data.
REQ-009 switches  input  N_SW  raw asynchronous switch levels, high = on.
REQ-010 data  output  32  registered read data.
REQ-011 irq  output  1  registered level interrupt.

Function
REQ-012 Register map: BASE+0 STATE (RO, debounced levels), BASE+4 CHANGED (sticky flags, W1C), BASE+8 IRQ_EN (RW mask); all N_SW bits, zero-extended to 32.
REQ-013 Each switch bit SHALL pass a 2-flop synchroniser before any other use.
REQ-014 Per channel, a counter of width clog2(DBNC_CYC+1) SHALL clear on any cycle where synchronised level equals debounced level, else increment.
REQ-015 Debounced bit SHALL take the synchronised level on the DBNC_CYC-th consecutive differing edge; counter clears on the same edge.
REQ-016 Latency: level change stable before edge k SHALL appear in STATE at edge k+1+DBNC_CYC; a glitch shorter than DBNC_CYC synchronised cycles SHALL produce no change.
REQ-017 Each debounced-bit update SHALL set the matching CHANGED bit at the same edge.
REQ-018 Write to BASE+4: CHANGED bits with wdata=1 clear; if the same bit is set and cleared on one edge, set wins.
REQ-019 Write to BASE+8 SHALL load IRQ_EN with wdata[N_SW-1:0]; writes to BASE+0 and unmapped addresses SHALL be ignored.
REQ-020 Read: on an edge where addr matches a mapped register and we=0, data SHALL load that register's value (value before that edge's updates); 1-cycle latency.
REQ-021 When addr is unmapped or we=1, data SHALL hold its previous value.
REQ-022 irq SHALL register |(CHANGED & IRQ_EN), one edge after either operand changes.
REQ-023 Bits N_SW..31 of every read SHALL be 0.

Reset
REQ-024 On rst: data=0, irq=0, STATE=0, CHANGED=0, IRQ_EN=0, synchronisers=0, counters=0.
REQ-025 rst asserted mid-debounce SHALL abort the count; no CHANGED bit SHALL be set by switches already high at reset release until they pass the full debounce (they differ from STATE=0).
REQ-026 Reset release SHALL not be synchronised internally; upstream reset synchroniser is assumed by the SoC top.

Structure
REQ-027 Register offsets (STATE=0, CHANGED=4, IRQ_EN=8) SHALL live in shared package pe_soc_pkg with other peripheral address constants.
REQ-028 Sub-module pe_dbnc_bit (synchroniser + counter + debounced flop + update pulse, parameter DBNC_CYC) SHALL be instantiated N_SW times by generate.
REQ-029 Top level holds register decode, CHANGED/IRQ_EN flops, read mux, irq flop.

Verification
REQ-030 N_SW=24, DBNC_CYC=4: switches=24'h00000F held; STATE reads 0 until edge k+5, then read gives 32'h0000000F; CHANGED=32'h0000000F.
REQ-031 Glitch: switches[0] high for 3 cycles then low, DBNC_CYC=4 -> STATE and CHANGED stay 0, irq stays 0.
REQ-032 IRQ_EN=1, bit0 changes -> irq=1 one edge after CHANGED[0] sets; write 32'h1 to BASE+4 -> CHANGED[0]=0, irq=0 next edge.
REQ-033 Bit0 update coincides with W1C of bit0 -> CHANGED[0] remains 1.
REQ-034 Read BASE+0 then addr=12'h0C0 for 10 cycles while switches change -> data holds last STATE value.
REQ-035 rst pulse mid-count with switches=24'hFFFFFF -> all regs 0 immediately; STATE=32'h00FFFFFF exactly 1+DBNC_CYC edges after release.
